serial_result_deserializer: RTL and testbench

Receive-side companion to the serial adder datapath. Accepts an LSB-first serial result stream plus a final carry, reassembles it into a parallel word, and presents it on a valid/ready output handshake. It sits downstream of a bit-serial arithmetic unit and feeds parallel consumers, such as registers or display logic.

---
 rtl/serial_result_deserializer.sv | 152 +++++++++++++++
 tb/tb_serial_result_deserializer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/serial_result_deserializer.sv
// Reassembles an LSB-first serial result stream plus final carry into a parallel
// word with a valid/ready output. Define SERIAL_PARITY_EN for a trailing even-parity bit.
module serial_result_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             SerialDin,
  input  logic             Start,
  input  logic             CarryIn,
  input  logic             OverrunClr,
  input  logic             DoutReady,
  output logic [WIDTH-1:0] ParallelDout,
  output logic             CarryOut,
  output logic             DoutValid,
  output logic             Busy,
  output logic             Overrun,
  output logic             ParityErr
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
`ifdef SERIAL_PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif
  localparam logic [1:0] VALID  = 2'd3;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_dout;
  logic             r_carryOut;
  logic             r_valid;
  logic             r_busy;
  logic             r_overrun;
`ifdef SERIAL_PARITY_EN
  logic             r_carry;
  logic             r_parErr;
`endif

  logic [WIDTH-1:0] w_shiftNext;
  logic             w_last;
  logic             w_ovSet;

  // New bits enter at the MSB so the first bit lands at the LSB after WIDTH samples
  assign w_shiftNext = {SerialDin, r_shift[WIDTH-1:1]};
  assign w_last      = (r_count == CNT_W'(WIDTH - 1));
  assign w_ovSet     = (r_state == VALID) && Start && !DoutReady;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_count    <= '0;
      r_dout     <= '0;
      r_carryOut <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
`ifdef SERIAL_PARITY_EN
      r_carry    <= 1'b0;
      r_parErr   <= 1'b0;
`endif
    end else begin
      // Set wins over a simultaneous clear
      if (w_ovSet)
        r_overrun <= 1'b1;
      else if (OverrunClr)
        r_overrun <= 1'b0;

      case (r_state)
        IDLE: begin
          if (Start) begin
            r_shift <= w_shiftNext;
            r_count <= CNT_W'(1);
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end

        SHIFT: begin
          r_shift <= w_shiftNext;
          if (Start) begin
            r_count <= CNT_W'(1);
          end else begin
            r_count <= r_count + CNT_W'(1);
            if (w_last) begin
`ifdef SERIAL_PARITY_EN
              r_carry <= CarryIn;
              r_state <= PARITY;
`else
              r_dout     <= w_shiftNext;
              r_carryOut <= CarryIn;
              r_valid    <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= VALID;
`endif
            end
          end
        end

`ifdef SERIAL_PARITY_EN
        PARITY: begin
          if (Start) begin
            r_shift <= w_shiftNext;
            r_count <= CNT_W'(1);
            r_state <= SHIFT;
          end else begin
            r_dout     <= r_shift;
            r_carryOut <= r_carry;
            r_parErr   <= (^r_shift) ^ SerialDin;
            r_valid    <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= VALID;
          end
        end
`endif

        VALID: begin
          // A Start without a handshake is discarded; the held word stays put
          if (DoutReady) begin
            r_valid <= 1'b0;
            if (Start) begin
              r_shift <= w_shiftNext;
              r_count <= CNT_W'(1);
              r_busy  <= 1'b1;
              r_state <= SHIFT;
            end else begin
              r_state <= IDLE;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign ParallelDout = r_dout;
  assign CarryOut     = r_carryOut;
  assign DoutValid    = r_valid;
  assign Busy         = r_busy;
  assign Overrun      = r_overrun;
`ifdef SERIAL_PARITY_EN
  assign ParityErr    = r_parErr;
`else
  assign ParityErr    = 1'b0;
`endif

endmodule

// File: tb/tb_serial_result_deserializer.sv
// Scoreboard bench for serial_result_deserializer: stimulus pushes expected words,
// a negedge monitor pops and compares on every handshake and checks hold stability.
module tb_serial_result_deserializer;

  localparam int WIDTH = 4;

  logic             Clk;
  logic             Rst_n;
  logic             SerialDin;
  logic             Start;
  logic             CarryIn;
  logic             OverrunClr;
  logic             DoutReady;
  logic [WIDTH-1:0] ParallelDout;
  logic             CarryOut;
  logic             DoutValid;
  logic             Busy;
  logic             Overrun;
  logic             ParityErr;

  int total = 0;
  int bad   = 0;

  // Expected entry layout: {parityErr, carry, word}
  logic [WIDTH+1:0] expQ[$];

  serial_result_deserializer #(.WIDTH(WIDTH)) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .SerialDin    (SerialDin),
    .Start        (Start),
    .CarryIn      (CarryIn),
    .OverrunClr   (OverrunClr),
    .DoutReady    (DoutReady),
    .ParallelDout (ParallelDout),
    .CarryOut     (CarryOut),
    .DoutValid    (DoutValid),
    .Busy         (Busy),
    .Overrun      (Overrun),
    .ParityErr    (ParityErr)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs and advance to just after the next rising edge
  task automatic applyStimulus(input logic st, input logic din, input logic cy,
                               input logic rdy, input logic clr);
    Start      = st;
    SerialDin  = din;
    CarryIn    = cy;
    DoutReady  = rdy;
    OverrunClr = clr;
    @(posedge Clk);
    #1;
  endtask

  // Send one complete frame (bit 0 first); carry is presented only with the last bit
  task automatic sendFrame(input logic [WIDTH-1:0] bits, input logic cy,
                           input logic rdy, input logic badParity);
    logic pe;
    pe = 1'b0;
`ifdef SERIAL_PARITY_EN
    pe = badParity;
`endif
    expQ.push_back({pe, cy, bits});
    for (int i = 0; i < WIDTH; i++) begin
      applyStimulus(i == 0, bits[i], (i == WIDTH - 1) ? cy : ~cy, rdy, 1'b0);
      if (i == 0) checkOutput("busy after start", 32'(Busy), 32'd1);
    end
`ifdef SERIAL_PARITY_EN
    applyStimulus(1'b0, (^bits) ^ badParity, 1'b0, rdy, 1'b0);
`else
    if (badParity) $display("[TB] note: parity request ignored in this build");
`endif
    checkOutput("valid latency", 32'(DoutValid), 32'd1);
    checkOutput("busy at valid", 32'(Busy), 32'd0);
  endtask

  // Monitor: pop on handshake, compare against queue head while the word is held
  always @(negedge Clk) begin
    if (Rst_n && DoutValid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected valid", 32'(DoutValid), 32'd0);
      end else begin
        checkOutput("word", 32'(ParallelDout), 32'(expQ[0][WIDTH-1:0]));
        checkOutput("carry", 32'(CarryOut), 32'(expQ[0][WIDTH]));
        checkOutput("parity err", 32'(ParityErr), 32'(expQ[0][WIDTH+1]));
        if (DoutReady) void'(expQ.pop_front());
      end
    end
  end

  initial begin
    Rst_n      = 1'b0;
    SerialDin  = 1'b0;
    Start      = 1'b0;
    CarryIn    = 1'b0;
    OverrunClr = 1'b0;
    DoutReady  = 1'b0;

    // Reset values
    #3;
    checkOutput("rst dout", 32'(ParallelDout), 32'd0);
    checkOutput("rst carry", 32'(CarryOut), 32'd0);
    checkOutput("rst valid", 32'(DoutValid), 32'd0);
    checkOutput("rst busy", 32'(Busy), 32'd0);
    checkOutput("rst overrun", 32'(Overrun), 32'd0);
    checkOutput("rst parity", 32'(ParityErr), 32'd0);
    #4 Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    // Basic frame with consumer always ready
    sendFrame(4'b1101, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("valid drops", 32'(DoutValid), 32'd0);

    // Held word, then handshake with a new Start on the same cycle
    sendFrame(4'b1100, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("held dout", 32'(ParallelDout), 32'h0000000c);
    checkOutput("held carry", 32'(CarryOut), 32'd1);
    sendFrame(4'b0001, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Overrun set, set-wins-over-clear, then clear with handshake
    sendFrame(4'b1001, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("overrun set", 32'(Overrun), 32'd1);
    checkOutput("overrun dout", 32'(ParallelDout), 32'h00000009);
    checkOutput("overrun valid", 32'(DoutValid), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("overrun set wins", 32'(Overrun), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("overrun cleared", 32'(Overrun), 32'd0);
    checkOutput("valid after clr", 32'(DoutValid), 32'd0);

    // Abort after two bits and restart
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    sendFrame(4'b1010, 1'b0, 1'b1, 1'b0);
    checkOutput("abort no overrun", 32'(Overrun), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-frame, then a clean frame
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("busy mid-frame", 32'(Busy), 32'd1);
    #2 Rst_n = 1'b0;
    #1;
    checkOutput("async rst busy", 32'(Busy), 32'd0);
    checkOutput("async rst dout", 32'(ParallelDout), 32'd0);
    checkOutput("async rst valid", 32'(DoutValid), 32'd0);
    #1 Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    sendFrame(4'b0111, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef SERIAL_PARITY_EN
    sendFrame(4'b1101, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    sendFrame(4'b1101, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("queue drained", 32'(expQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
